// File: rtl/usb_tx_pkg.sv
// Shared types for the USB endpoint transmit path: packet codes handed to the
// TX control logic, handshake request types and the scheduler state encoding.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    PKT_NONE  = 3'd0,
    PKT_DATA  = 3'd1,
    PKT_ACK   = 3'd2,
    PKT_NAK   = 3'd3,
    PKT_STALL = 3'd4
  } tx_packet_t;

  typedef enum logic [1:0] {
    HS_ACK   = 2'd0,
    HS_NAK   = 2'd1,
    HS_STALL = 2'd2,
    HS_RSVD  = 2'd3
  } hs_type_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_XFER,
    ST_AWAIT_ACK
  } sched_state_t;

  // Packet code sent for a stored handshake type; reserved maps to nothing.
  function automatic tx_packet_t hs_to_packet(hs_type_t t);
    case (t)
      HS_ACK:   return PKT_ACK;
      HS_NAK:   return PKT_NAK;
      HS_STALL: return PKT_STALL;
      default:  return PKT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tx_packet_scheduler_if.sv
// Request, status and TX-control signals of the transmit scheduler.
// The master modport is the scheduler's view; slave is the surrounding logic.
interface tx_packet_scheduler_if;
  import usb_tx_pkg::*;

  logic       in_token;
  logic       hs_req;
  logic [1:0] hs_type;
  logic       rx_host_ack;
  logic       data_ready;
  logic [6:0] buffer_occupancy;
  logic       tx_transfer_active;
  logic       tx_error;
  tx_packet_t tx_packet;
  logic       data_pid;
  logic       sched_busy;
  logic       pkt_done;
  logic       data_acked;
  logic       sched_error;

  modport master (
    input  in_token, hs_req, hs_type, rx_host_ack, data_ready,
           buffer_occupancy, tx_transfer_active, tx_error,
    output tx_packet, data_pid, sched_busy, pkt_done, data_acked, sched_error
  );

  modport slave (
    output in_token, hs_req, hs_type, rx_host_ack, data_ready,
           buffer_occupancy, tx_transfer_active, tx_error,
    input  tx_packet, data_pid, sched_busy, pkt_done, data_acked, sched_error
  );

endinterface

// File: rtl/tx_req_arbiter.sv
// Holds pending transmit requests and picks the winner by fixed priority:
// STALL, then ACK/NAK, then the IN response (DATA if a packet is buffered).
module tx_req_arbiter
  import usb_tx_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       in_token,
  input  logic       hs_req,
  input  logic [1:0] hs_type,
  input  logic       data_ready,
  input  logic [6:0] buffer_occupancy,
  input  logic       grant,
  output logic       req_valid,
  output tx_packet_t req_packet
);

  logic     stall_pend, hs_pend, in_pend;
  hs_type_t hs_type_q;
  hs_type_t hs_in;
  logic     set_stall, set_hs;
  logic     sel_stall, sel_hs, sel_in;

  assign hs_in     = hs_type_t'(hs_type);
  assign set_stall = hs_req && (hs_in == HS_STALL);
  assign set_hs    = hs_req && (hs_in == HS_ACK || hs_in == HS_NAK);

  assign sel_stall = stall_pend;
  assign sel_hs    = !stall_pend && hs_pend;
  assign sel_in    = !stall_pend && !hs_pend && in_pend;
  assign req_valid = stall_pend || hs_pend || in_pend;

  // Packet code of the current winner; the IN response is decided at grant time.
  always_comb begin
    // NOTE: default first so every path assigns req_packet and no latch is inferred.
    req_packet = PKT_NONE;
    if (sel_stall)   req_packet = PKT_STALL;
    else if (sel_hs) req_packet = hs_to_packet(hs_type_q);
    else if (sel_in) req_packet = (data_ready && buffer_occupancy != 7'd0) ? PKT_DATA : PKT_NAK;
  end

  // Pending flags: a new pulse wins over a same-cycle grant so it is never lost.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
      stall_pend <= 1'b0;
      hs_pend    <= 1'b0;
      in_pend    <= 1'b0;
      hs_type_q  <= HS_ACK;
    end else begin
      stall_pend <= set_stall || (stall_pend && !(grant && sel_stall));
      hs_pend    <= set_hs    || (hs_pend    && !(grant && sel_hs));
      in_pend    <= in_token  || (in_pend    && !(grant && sel_in));
      if (set_hs) hs_type_q <= hs_in;
    end
  end

endmodule

// File: rtl/tx_packet_scheduler.sv
// Transmit scheduler: grants one request at a time, presents its packet code
// to the TX control logic until the transfer starts, waits for completion and,
// for DATA packets, for the host ACK that advances the DATA0/DATA1 toggle.
module tx_packet_scheduler
  import usb_tx_pkg::*;
#(
  parameter int START_TIMEOUT = 4,
  parameter int ACK_TIMEOUT   = 64
) (
  input  logic clk,
  input  logic n_rst,
  tx_packet_scheduler_if.master sif
);

  localparam int CNT_MAX = (START_TIMEOUT > ACK_TIMEOUT) ? START_TIMEOUT : ACK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  sched_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       is_data_q, is_data_d;
  tx_packet_t pkt_q, pkt_d;
  logic       pid_q, pid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       acked_q, acked_d;
  logic       err_q, err_d;
  logic       grant, req_valid;
  tx_packet_t req_packet;

  tx_req_arbiter u_arb (
    .clk              (clk),
    .n_rst            (n_rst),
    .in_token         (sif.in_token),
    .hs_req           (sif.hs_req),
    .hs_type          (sif.hs_type),
    .data_ready       (sif.data_ready),
    .buffer_occupancy (sif.buffer_occupancy),
    .grant            (grant),
    .req_valid        (req_valid),
    .req_packet       (req_packet)
  );

  // Next state, timeout counter and registered-output values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    is_data_d = is_data_q;
    pkt_d     = PKT_NONE;
    pid_d     = pid_q;
    done_d    = 1'b0;
    acked_d   = 1'b0;
    err_d     = 1'b0;
    grant     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req_valid) begin
          grant     = 1'b1;
          pkt_d     = req_packet;
          is_data_d = (req_packet == PKT_DATA);
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (sif.tx_transfer_active) begin
          state_d = ST_XFER;
        end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          pkt_d = pkt_q;
        end
      end
      ST_XFER: begin
        if (!sif.tx_transfer_active) begin
          done_d  = 1'b1;
          state_d = is_data_q ? ST_AWAIT_ACK : ST_IDLE;
        end
      end
      ST_AWAIT_ACK: begin
        if (sif.rx_host_ack) begin
          acked_d = 1'b1;
          pid_d   = ~pid_q;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A TX error aborts whatever is in flight; the PID toggle is left alone.
    if (state_q != ST_IDLE && sif.tx_error) begin
      state_d = ST_IDLE;
      pkt_d   = PKT_NONE;
      pid_d   = pid_q;
      done_d  = 1'b0;
      acked_d = 1'b0;
      err_d   = 1'b1;
    end

    if (state_d != state_q) cnt_d = '0;
    busy_d = (state_d != ST_IDLE);
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      is_data_q <= 1'b0;
      pkt_q     <= PKT_NONE;
      pid_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      acked_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_data_q <= is_data_d;
      pkt_q     <= pkt_d;
      pid_q     <= pid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      acked_q   <= acked_d;
      err_q     <= err_d;
    end
  end

  assign sif.tx_packet   = pkt_q;
  assign sif.data_pid    = pid_q;
  assign sif.sched_busy  = busy_q;
  assign sif.pkt_done    = done_q;
  assign sif.data_acked  = acked_q;
  assign sif.sched_error = err_q;

endmodule

// File: tb/tb_tx_packet_scheduler.sv
// Directed bench for tx_packet_scheduler. Expected packets (code and PID) are
// queued when a request is driven and compared when the packet appears.
module tb_tx_packet_scheduler;
  import usb_tx_pkg::*;

  localparam int START_TO = 4;
  localparam int ACK_TO   = 64;

  typedef struct {
    tx_packet_t pkt;
    logic       pid;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  tx_packet_scheduler_if sif();

  tx_packet_scheduler #(.START_TIMEOUT(START_TO), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .sif   (sif)
  );

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int n_done = 0, n_acked = 0, n_err = 0, n_issue = 0;
  int snap_done, snap_acked, snap_issue;
  tx_packet_t prev_pkt = PKT_NONE;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Monitor: pulse counters and scoreboard pop on each new packet code.
  always @(negedge clk) begin
    exp_t e;
    if (sif.pkt_done)    n_done++;
    if (sif.data_acked)  n_acked++;
    if (sif.sched_error) n_err++;
    if (sif.tx_packet != PKT_NONE) n_issue++;
    if (sif.tx_packet != PKT_NONE && prev_pkt == PKT_NONE) begin
      if (sb.size() == 0) begin
        check("unexpected_packet", sif.tx_packet, PKT_NONE);
      end else begin
        e = sb.pop_front();
        check("sb_packet", sif.tx_packet, e.pkt);
        check("sb_pid", sif.data_pid, e.pid);
      end
    end
    prev_pkt = sif.tx_packet;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_in();
    sif.in_token = 1'b1;
    tick();
    sif.in_token = 1'b0;
  endtask

  task automatic wait_packet(input tx_packet_t exp);
    for (int i = 0; i < 12 && sif.tx_packet == PKT_NONE; i++) tick();
    check("wait_packet", sif.tx_packet, exp);
  endtask

  // Model the TX control logic: start after 'delay' cycles, stay active 'len' cycles.
  task automatic serve(input int delay, input int len);
    repeat (delay) tick();
    sif.tx_transfer_active = 1'b1;
    repeat (len) tick();
    sif.tx_transfer_active = 1'b0;
    tick();
  endtask

  task automatic host_ack();
    sif.rx_host_ack = 1'b1;
    tick();
    sif.rx_host_ack = 1'b0;
  endtask

  initial begin
    sif.in_token = 1'b0; sif.hs_req = 1'b0; sif.hs_type = 2'd0;
    sif.rx_host_ack = 1'b0; sif.data_ready = 1'b0; sif.buffer_occupancy = 7'd0;
    sif.tx_transfer_active = 1'b0; sif.tx_error = 1'b0;
    n_rst = 1'b1;
    #1 n_rst = 1'b0;
    repeat (3) tick();
    check("rst_tx_packet", sif.tx_packet, PKT_NONE);
    check("rst_data_pid", sif.data_pid, 1'b0);
    check("rst_busy", sif.sched_busy, 1'b0);
    check("rst_pkt_done", sif.pkt_done, 1'b0);
    check("rst_data_acked", sif.data_acked, 1'b0);
    check("rst_sched_error", sif.sched_error, 1'b0);
    n_rst = 1'b1;
    tick();

    // DATA0 transfer with host ACK; two-cycle request latency.
    sif.data_ready = 1'b1; sif.buffer_occupancy = 7'd8;
    snap_issue = n_issue; snap_done = n_done; snap_acked = n_acked;
    sb.push_back('{PKT_DATA, 1'b0});
    pulse_in();
    tick();
    check("latency_data", sif.tx_packet, PKT_DATA);
    check("issue_busy", sif.sched_busy, 1'b1);
    serve(1, 3);
    check("data_issue_cycles", n_issue - snap_issue, 2);
    check("data_pkt_done", n_done - snap_done, 1);
    check("await_ack_busy", sif.sched_busy, 1'b1);
    tick();
    host_ack();
    check("data_acked_pulse", sif.data_acked, 1'b1);
    check("pid_toggled", sif.data_pid, 1'b1);
    check("idle_after_ack", sif.sched_busy, 1'b0);
    tick();
    check("data_acked_once", n_acked - snap_acked, 1);

    // Empty buffer: IN answered with NAK, no ACK wait.
    sif.buffer_occupancy = 7'd0;
    sb.push_back('{PKT_NAK, 1'b1});
    pulse_in();
    wait_packet(PKT_NAK);
    serve(0, 1);
    check("nak_pkt_done", sif.pkt_done, 1'b1);
    check("nak_no_await", sif.sched_busy, 1'b0);
    check("nak_pid_kept", sif.data_pid, 1'b1);

    // STALL and IN in the same cycle: STALL first, IN served afterwards.
    sif.buffer_occupancy = 7'd8;
    sb.push_back('{PKT_STALL, 1'b1});
    sb.push_back('{PKT_DATA, 1'b1});
    sif.hs_req = 1'b1; sif.hs_type = 2'd2;
    pulse_in();
    sif.hs_req = 1'b0;
    wait_packet(PKT_STALL);
    serve(0, 2);
    check("stall_no_await", sif.sched_busy, 1'b0);
    wait_packet(PKT_DATA);
    serve(0, 2);
    check("data_await", sif.sched_busy, 1'b1);

    // No host ACK: error exactly ACK_TO cycles after entering AWAIT_ACK.
    repeat (ACK_TO - 1) tick();
    check("ack_to_early", sif.sched_error, 1'b0);
    tick();
    check("ack_to_error", sif.sched_error, 1'b1);
    check("ack_to_idle", sif.sched_busy, 1'b0);
    check("ack_to_pid_kept", sif.data_pid, 1'b1);

    // Retry resends the same PID; this time it is acknowledged.
    sb.push_back('{PKT_DATA, 1'b1});
    pulse_in();
    wait_packet(PKT_DATA);
    serve(0, 1);
    host_ack();
    check("retry_acked", sif.data_acked, 1'b1);
    check("retry_pid", sif.data_pid, 1'b0);

    // Start timeout; meanwhile ACK then NAK requests (NAK overwrites) and a reserved type.
    sif.data_ready = 1'b0;
    sb.push_back('{PKT_NAK, 1'b0});
    pulse_in();
    wait_packet(PKT_NAK);
    sif.hs_req = 1'b1; sif.hs_type = 2'd0;
    tick();
    sb.push_back('{PKT_NAK, 1'b0});
    sif.hs_type = 2'd1;
    tick();
    sif.hs_type = 2'd3;
    tick();
    sif.hs_req = 1'b0; sif.hs_type = 2'd0;
    check("start_to_early", sif.sched_error, 1'b0);
    check("start_to_hold", sif.tx_packet, PKT_NAK);
    tick();
    check("start_to_error", sif.sched_error, 1'b1);
    check("start_to_none", sif.tx_packet, PKT_NONE);
    check("start_to_idle", sif.sched_busy, 1'b0);
    wait_packet(PKT_NAK);
    serve(0, 1);
    repeat (3) tick();
    check("no_extra_packet", sif.tx_packet, PKT_NONE);

    // tx_error during XFER aborts without completion, PID unchanged.
    sif.data_ready = 1'b1;
    sb.push_back('{PKT_DATA, 1'b0});
    pulse_in();
    wait_packet(PKT_DATA);
    sif.tx_transfer_active = 1'b1;
    tick();
    tick();
    snap_done = n_done;
    sif.tx_error = 1'b1;
    tick();
    sif.tx_error = 1'b0;
    sif.tx_transfer_active = 1'b0;
    check("txerr_error", sif.sched_error, 1'b1);
    check("txerr_idle", sif.sched_busy, 1'b0);
    check("txerr_pid", sif.data_pid, 1'b0);
    tick();
    check("txerr_no_done", n_done - snap_done, 0);

    // Advance PID to 1, then reset in the middle of a transfer.
    sb.push_back('{PKT_DATA, 1'b0});
    pulse_in();
    wait_packet(PKT_DATA);
    serve(0, 1);
    host_ack();
    check("pid_before_reset", sif.data_pid, 1'b1);
    sb.push_back('{PKT_DATA, 1'b1});
    pulse_in();
    wait_packet(PKT_DATA);
    sif.tx_transfer_active = 1'b1;
    tick();
    tick();
    check("xfer_busy", sif.sched_busy, 1'b1);
    n_rst = 1'b0;
    #1;
    check("midrst_tx_packet", sif.tx_packet, PKT_NONE);
    check("midrst_pid", sif.data_pid, 1'b0);
    check("midrst_busy", sif.sched_busy, 1'b0);
    check("midrst_done", sif.pkt_done, 1'b0);
    sif.tx_transfer_active = 1'b0;
    tick();
    n_rst = 1'b1;
    snap_done = n_done;
    repeat (5) tick();
    check("postrst_no_done", n_done - snap_done, 0);
    check("postrst_idle", sif.sched_busy, 1'b0);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
